// File: rtl/iic_pkg.sv
// Shared constants for the 16-bit-address I2C master: state codes, quarter
// phases, byte selectors, transaction lengths and the quarter-period divider.
package iic_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_SEND   = 3'd2;
  localparam logic [2:0] ST_RSTART = 3'd3;
  localparam logic [2:0] ST_RECV   = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [2:0] IDX_DEV  = 3'd0;
  localparam logic [2:0] IDX_AH   = 3'd1;
  localparam logic [2:0] IDX_AL   = 3'd2;
  localparam logic [2:0] IDX_DAT  = 3'd3;
  localparam logic [2:0] IDX_DEVR = 3'd4;

  localparam int unsigned WR_QUARTERS = 152;
  localparam int unsigned RD_QUARTERS = 192;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned iic_freq);
    return clk_freq / (4 * iic_freq);
  endfunction

endpackage

// File: rtl/iic_qtick_gen.sv
// Quarter-bit tick generator: DIV-cycle counter plus a 2-bit phase, both held
// at zero while disabled.
module iic_qtick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign tick  = en & (cnt_q == CW'(DIV - 1));
  assign phase = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/iic_master_16b.sv
// Single-register I2C write/read engine for 16-bit-addressed slaves; one
// transaction per trigger, completion via busy fall and a byte_over pulse.
module iic_master_16b
  import iic_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned IIC_FREQ = 100_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        iic_trig,
  input  logic        w_r,
  input  logic [7:0]  device_id,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [7:0]  data_out,
  output logic        byte_over,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, IIC_FREQ);

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  dev_q, dev_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dat_q, dat_d;
  logic        wr_q, wr_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        busy_q, busy_d;
  logic        byte_over_q, byte_over_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [1:0]  sync_q, sync_d;

  logic        q_en, qtick, q_last, q_sample, sda_s;
  logic [1:0]  phase;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  assign q_en = (state_q != ST_IDLE);

  iic_qtick_gen #(.DIV(DIV)) u_qtick (
    .clk   (clk),
    .rstn  (rstn),
    .en    (q_en),
    .tick  (qtick),
    .phase (phase)
  );

  assign q_last   = qtick & (phase == Q3);
  assign q_sample = qtick & (phase == Q2);
  assign sda_s    = sync_q[1];

  always_comb begin
    case (idx_q)
      IDX_AH:   tx_byte = addr_q[15:8];
      IDX_AL:   tx_byte = addr_q[7:0];
      IDX_DAT:  tx_byte = dat_q;
      IDX_DEVR: tx_byte = dev_q | 8'h01;
      default:  tx_byte = dev_q;
    endcase
    // bit index 8 is the slave ACK slot, so SDA is released there
    tx_bit = bit_q[3] ? 1'b1 : tx_byte[~bit_q[2:0]];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bit_d       = bit_q;
    dev_d       = dev_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    wr_d        = wr_q;
    rx_d        = rx_q;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    byte_over_d = 1'b0;
    ack_err_d   = ack_err_q;
    sync_d      = {sync_q[0], sda_in};
    scl_d       = 1'b0;
    sda_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iic_trig) begin
          dev_d     = device_id;
          addr_d    = addr;
          dat_d     = data_in;
          wr_d      = w_r;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          idx_d     = IDX_DEV;
          bit_d     = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        sda_d = (phase == Q2) || (phase == Q3);
        scl_d = (phase == Q3);
        if (q_last) begin
          bit_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        scl_d = (phase == Q0) || (phase == Q3);
        sda_d = ~tx_bit;
        if (q_sample && bit_q[3] && sda_s)
          ack_err_d = 1'b1;
        if (q_last) begin
          if (!bit_q[3]) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = '0;
            if (ack_err_q) begin
              state_d = ST_STOP;
            end else begin
              case (idx_q)
                IDX_DEV: idx_d = IDX_AH;
                IDX_AH:  idx_d = IDX_AL;
                IDX_AL: begin
                  if (wr_q) idx_d = IDX_DAT;
                  else      state_d = ST_RSTART;
                end
                IDX_DAT: begin
                  state_d     = ST_STOP;
                  byte_over_d = 1'b1;
                end
                default: state_d = ST_RECV;
              endcase
            end
          end
        end
      end
      ST_RSTART: begin
        scl_d = (phase == Q0) || (phase == Q3);
        sda_d = (phase == Q2) || (phase == Q3);
        if (q_last) begin
          idx_d   = IDX_DEVR;
          bit_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_RECV: begin
        scl_d = (phase == Q0) || (phase == Q3);
        if (q_sample && !bit_q[3])
          rx_d = {rx_q[6:0], sda_s};
        if (q_last) begin
          if (!bit_q[3]) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d       = '0;
            state_d     = ST_STOP;
            byte_over_d = 1'b1;
            data_out_d  = rx_q;
          end
        end
      end
      ST_STOP: begin
        scl_d = (phase == Q0);
        sda_d = (phase == Q0) || (phase == Q1);
        if (q_last) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_DEV;
      bit_q       <= '0;
      dev_q       <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
      wr_q        <= 1'b0;
      rx_q        <= '0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      byte_over_q <= 1'b0;
      ack_err_q   <= 1'b0;
      scl_q       <= 1'b0;
      sda_q       <= 1'b0;
      sync_q      <= '1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bit_q       <= bit_d;
      dev_q       <= dev_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      wr_q        <= wr_d;
      rx_q        <= rx_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      byte_over_q <= byte_over_d;
      ack_err_q   <= ack_err_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      sync_q      <= sync_d;
    end
  end

  assign busy      = busy_q;
  assign data_out  = data_out_q;
  assign byte_over = byte_over_q;
  assign ack_err   = ack_err_q;
  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;

endmodule

// File: doc/iic_master_16b.md
# iic_master_16b

I2C byte-transaction engine that executes single-register accesses on 16-bit-addressed I2C devices such as the MS7210 HDMI transmitter. It sits between the MS7210 configuration controller and the board SCL/SDA pads. It accepts one register write or read per trigger pulse. It reports completion through a `busy` falling edge and a one-cycle `byte_over` pulse.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `IIC_FREQ`, 100_000: SCL frequency in Hz. `DIV = CLK_FREQ/(4*IIC_FREQ)` sets the quarter-bit period in clk cycles; `DIV` ≥ 4.
- `clk` in 1: system clock; the block uses this single clock only.
- `rstn` in 1: asynchronous, active-low reset.
- `iic_trig` in 1: start a transaction; sampled only while idle.
- `w_r` in 1: 1 = register write, 0 = register read.
- `device_id` in 8: 8-bit write-form slave address, e.g. 8'hB2. The read form is `device_id | 1`.
- `addr` in 16: register address, sent high byte first.
- `data_in` in 8: write data.
- `busy` out 1: high while a transaction is in progress.
- `data_out` out 8: read data; valid from the `busy` falling edge and held until the next read completes.
- `byte_over` out 1: one-cycle pulse when a transaction completes successfully.
- `ack_err` out 1: slave NACK seen in the last transaction; cleared on the next accepted trigger.
- `scl_oe` out 1: 1 pulls SCL low; 0 releases it (open drain).
- `sda_oe` out 1: 1 pulls SDA low; 0 releases it.
- `sda_in` in 1: SDA pad level; synchronised internally by a 2-flop synchroniser.

## Operation
- **Reset values:** `busy`=0, `byte_over`=0, `data_out`=8'h00, `ack_err`=0, `scl_oe`=0, `sda_oe`=0. Internal state is IDLE.
- **IDLE:**
  - When `iic_trig`=1, capture `device_id`, `addr`, `data_in` and `w_r` into shadow registers.
  - Set `busy`=1 and clear `ack_err`, then go to START.
  - Input changes after capture have no effect on the bus.
  - A trigger while `busy`=1 is ignored.
- **Write sequence:** START, `device_id`, `addr[15:8]`, `addr[7:0]`, `data_in`, STOP. Each byte is followed by a slave ACK bit.
- **Read sequence:**
  - START, `device_id`, `addr[15:8]`, `addr[7:0]`.
  - Repeated START, then `device_id|1`.
  - RECV 8 bits, MSB first, followed by a master NACK (SDA released), then STOP.
- **States:** IDLE, START, SEND (8 data bits + ACK bit), RSTART, RECV (8 bits + master NACK), STOP. A 3-bit byte index selects the next byte in SEND.
- **Bit timing:** each bit is 4 quarters.
  - q0: SCL low; drive SDA.
  - q1: release SCL.
  - q2: sample SDA while SCL is high.
  - q3: pull SCL low.
- **START:** SCL and SDA released, then SDA pulled low at q2, then SCL pulled low at q3.
- **RSTART:** SDA released at q0, SCL released at q1, SDA low at q2, SCL low at q3.
- **STOP:** SDA low at q0, SCL released at q1, SDA released at q2, and the bus stays idle through q3.
- **ACK sampling:** `sda_in`=1 at q2 of any slave ACK bit is a NACK. On NACK:
  - abort to STOP;
  - set `ack_err`=1;
  - do not pulse `byte_over`;
  - leave `data_out` unchanged.
- **Successful completion:** `byte_over` pulses at q0 of STOP and `data_out` updates on the same cycle. `busy` falls on the cycle after STOP q3.
- **No clock stretching;** SCL is never sampled.

## Timing
- `busy` rises 1 cycle after `iic_trig` is sampled.
- **Write:** 152 quarters (`152*DIV`), ±1 cycle, from `busy` rise to `busy` fall.
- **Read:** 192 quarters (`192*DIV`), ±1 cycle.
- `byte_over` leads the `busy` fall by `4*DIV` cycles, which is at least 16. The controller therefore has time to update `addr`/`data_in` from its command table.
- A trigger on the cycle after `busy` falls is accepted; there is no dead time.
- The quarter tick counter wraps from `DIV-1` to 0 and is held at 0 in IDLE.
- **Reset mid-transaction:** all outputs return to reset values asynchronously and the bus is released immediately. A partial byte on the bus is acceptable.

## Structure
- Package `iic_pkg` holds:
  - the state encoding constants;
  - the quarter-phase constants Q0..Q3;
  - the transaction lengths `WR_QUARTERS`=152 and `RD_QUARTERS`=192;
  - the `DIV` derivation.
- Sub-module `iic_qtick_gen` generates the quarter tick (a `DIV` counter with enable and a 2-bit phase output).
- The top level holds the FSM, the shift registers, the bit and byte counters, and the pad-enable registers.

## Test plan
- **Register write:** write to `device_id`=B2, `addr`=1281, `data_in`=04, with the slave ACKing every byte.
  - Decoded bus shows START B2 12 81 04 STOP.
  - `byte_over` pulses once; `busy` is high for `152*DIV`±1 cycles; `ack_err`=0.
- **Register read:** read `addr`=0003 with the slave returning 5A.
  - Decoded bus shows B2 00 03, then RSTART B3, then 5A with master NACK, then STOP.
  - `data_out`=5A at the `busy` fall.
- **NACK abort:** slave NACKs `addr[7:0]` → STOP follows immediately, `ack_err`=1, no `byte_over`. A retrigger clears `ack_err` and succeeds.
- **Input isolation:** pulse `iic_trig` and change `addr` while `busy`=1 → both are ignored and the bus bytes match the captured values.
- **Reset mid-transaction:** assert `rstn`=0 at the 3rd bit of the 2nd byte → `scl_oe`=`sda_oe`=`busy`=0 within the same cycle. After release, a new write completes correctly.
- **Back-to-back:** issue `iic_trig` the cycle after `busy` falls → the transaction is accepted and `busy` rises 1 cycle later.
